// File: rtl/lsb_queue_pkg.sv
// Shared encodings for the load/store queue: func3 codes, request lengths,
// the IO region marker and the issue FSM states.
package lsb_queue_pkg;

    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;
    localparam logic [2:0] FUNC3_SB  = 3'b000;
    localparam logic [2:0] FUNC3_SH  = 3'b001;
    localparam logic [2:0] FUNC3_SW  = 3'b010;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Access size in bytes; the low two func3 bits encode it for loads and stores alike.
    function automatic logic [2:0] len_of(input logic [2:0] f3);
        logic [2:0] len;
        case (f3[1:0])
            2'b00:   len = LEN_B;
            2'b01:   len = LEN_H;
            default: len = LEN_W;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/lsb_queue_if.sv
// Memory-controller channel of the load/store queue: one outstanding request,
// accepted on valid&ready, completed by a single-cycle response pulse.
interface lsb_queue_if #(
    parameter int XLEN = 32
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_is_store;
    logic [XLEN-1:0] mem_req_addr;
    logic [2:0]      mem_req_len;
    logic [XLEN-1:0] mem_req_data;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid, mem_req_is_store, mem_req_addr, mem_req_len, mem_req_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_is_store, mem_req_addr, mem_req_len, mem_req_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/lsb_wakeup.sv
// Tag match of one pending operand against all broadcast ports.
// When several ports carry the same tag the lowest port index supplies the data.
module lsb_wakeup #(
    parameter int NCDB  = 2,
    parameter int XLEN  = 32,
    parameter int ROB_W = 4
) (
    input  logic [ROB_W-1:0]      tag,
    input  logic [NCDB-1:0]       cdb_valid,
    input  logic [NCDB*ROB_W-1:0] cdb_rob_id,
    input  logic [NCDB*XLEN-1:0]  cdb_data,
    output logic                  hit,
    output logic [XLEN-1:0]       data
);

    // Scan from the highest port down so the lowest matching port is the last writer.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = NCDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && (cdb_rob_id[k*ROB_W +: ROB_W] == tag)) begin
                hit  = 1'b1;
                data = cdb_data[k*XLEN +: XLEN];
            end else begin
                hit  = hit;
                data = data;
            end
        end
    end

endmodule

// File: rtl/lsb_queue.sv
// In-order load/store queue. Entries capture operands from the CDB, stores and
// IO loads wait for commit, other loads issue speculatively from head. One
// memory request is outstanding at a time and always runs to completion.
module lsb_queue
    import lsb_queue_pkg::*;
#(
    parameter int         DEPTH = 16,
    parameter int         NCDB  = 2,
    parameter int         XLEN  = 32,
    parameter int         ROB_W = 4,
    parameter logic [1:0] IO_HI = IO_HI_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    output logic                  full,
    input  logic                  inst_valid,
    input  logic                  is_store,
    input  logic [2:0]            func3,
    input  logic                  rs1_busy,
    input  logic                  rs2_busy,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [ROB_W-1:0]      rs1_rob_id,
    input  logic [ROB_W-1:0]      rs2_rob_id,
    input  logic [XLEN-1:0]       imm,
    input  logic [ROB_W-1:0]      rob_target,
    input  logic [NCDB-1:0]       cdb_valid,
    input  logic [NCDB*ROB_W-1:0] cdb_rob_id,
    input  logic [NCDB*XLEN-1:0]  cdb_data,
    input  logic                  commit_valid,
    input  logic [ROB_W-1:0]      commit_rob_id,
    lsb_queue_if.master           mem,
    output logic                  out_valid,
    output logic [ROB_W-1:0]      out_rob_id,
    output logic [XLEN-1:0]       out_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] valid_r, committed_r, is_store_r, rs1_busy_r, rs2_busy_r;
    logic [2:0]       func3_r    [DEPTH];
    logic [XLEN-1:0]  rs1_data_r [DEPTH];
    logic [XLEN-1:0]  rs2_data_r [DEPTH];
    logic [ROB_W-1:0] rs1_tag_r  [DEPTH];
    logic [ROB_W-1:0] rs2_tag_r  [DEPTH];
    logic [XLEN-1:0]  imm_r      [DEPTH];
    logic [ROB_W-1:0] rob_r      [DEPTH];

    logic [AW-1:0] head_r, tail_r, head_nxt_s, tail_nxt_s;
    logic [CW-1:0] count_r, ncommit_r, count_nxt_s, ncommit_nxt_s;
    state_t        state_r, state_s;
    logic          discard_r, discard_nxt_s, discard_now_s, keep_s;
    logic          rsp_hold_r;
    logic [XLEN-1:0] rsp_hold_data_r;

    logic            mem_req_valid_r, mem_req_is_store_r;
    logic [XLEN-1:0] mem_req_addr_r, mem_req_data_r;
    logic [2:0]      mem_req_len_r;

    logic [DEPTH-1:0] w1_hit_s, w2_hit_s, commit_hit_s;
    logic [XLEN-1:0]  w1_data_s [DEPTH];
    logic [XLEN-1:0]  w2_data_s [DEPTH];
    logic             e1_hit_s, e2_hit_s;
    logic [XLEN-1:0]  e1_data_s, e2_data_s;

    logic            issue_s, deq_s, enq_s, commit_any_s;
    logic            head_committed_s, head_ready_s, rsp_s;
    logic [XLEN-1:0] head_addr_s, rsp_data_s, ext_s;

    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        lsb_wakeup #(.NCDB(NCDB), .XLEN(XLEN), .ROB_W(ROB_W)) u_rs1 (
            .tag(rs1_tag_r[g]), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
            .cdb_data(cdb_data), .hit(w1_hit_s[g]), .data(w1_data_s[g]));
        lsb_wakeup #(.NCDB(NCDB), .XLEN(XLEN), .ROB_W(ROB_W)) u_rs2 (
            .tag(rs2_tag_r[g]), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
            .cdb_data(cdb_data), .hit(w2_hit_s[g]), .data(w2_data_s[g]));
    end

    lsb_wakeup #(.NCDB(NCDB), .XLEN(XLEN), .ROB_W(ROB_W)) u_enq_rs1 (
        .tag(rs1_rob_id), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_data(cdb_data), .hit(e1_hit_s), .data(e1_data_s));
    lsb_wakeup #(.NCDB(NCDB), .XLEN(XLEN), .ROB_W(ROB_W)) u_enq_rs2 (
        .tag(rs2_rob_id), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_data(cdb_data), .hit(e2_hit_s), .data(e2_data_s));

    assign head_committed_s = committed_r[head_r];
    assign head_ready_s     = valid_r[head_r] && !rs1_busy_r[head_r] && !rs2_busy_r[head_r];
    assign head_addr_s      = rs1_data_r[head_r] + imm_r[head_r];
    assign rsp_s            = mem.mem_rsp_valid || rsp_hold_r;
    assign rsp_data_s       = mem.mem_rsp_valid ? mem.mem_rsp_data : rsp_hold_data_r;
    assign commit_any_s     = rdy && !rollback && (|commit_hit_s);
    // A dequeue frees the slot in the same cycle, so enqueue stays legal at full.
    assign enq_s            = rdy && inst_valid && !rollback && ((count_r != CW'(DEPTH)) || deq_s);
    assign full             = (count_r - CW'(deq_s) + CW'(enq_s)) == CW'(DEPTH);

    assign mem.mem_req_valid    = mem_req_valid_r;
    assign mem.mem_req_is_store = mem_req_is_store_r;
    assign mem.mem_req_addr     = mem_req_addr_r;
    assign mem.mem_req_len      = mem_req_len_r;
    assign mem.mem_req_data     = mem_req_data_r;

    // Issue FSM next state: head issue in IDLE, handshake in REQ, completion in WAIT.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        deq_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rdy && head_ready_s && (head_committed_s ||
                    (!is_store_r[head_r] && (head_addr_s[17:16] != IO_HI) && !rollback))) begin
                    state_s = ST_REQ;
                    issue_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (rdy && mem.mem_req_ready) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (rdy && rsp_s) begin
                    state_s = ST_IDLE;
                    deq_s   = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Which entry, if any, the ROB is committing this cycle.
    always_comb begin
        commit_hit_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            commit_hit_s[i] = commit_valid && valid_r[i] && !committed_r[i] && (rob_r[i] == commit_rob_id);
        end
    end

    // Pointer, occupancy and discard bookkeeping. On rollback a speculative
    // request still in flight keeps its slot at head so its response can retire
    // it; the committed entries follow it.
    always_comb begin
        head_nxt_s    = head_r + AW'(deq_s);
        ncommit_nxt_s = ncommit_r - CW'(deq_s && head_committed_s) + CW'(commit_any_s);
        keep_s        = (state_r != ST_IDLE) && !deq_s && !head_committed_s;
        discard_now_s = discard_r || (rollback && !head_committed_s);
        if (rollback) begin
            count_nxt_s = ncommit_nxt_s + CW'(keep_s);
            tail_nxt_s  = head_nxt_s + AW'(count_nxt_s);
        end else begin
            count_nxt_s = count_r - CW'(deq_s) + CW'(enq_s);
            tail_nxt_s  = tail_r + AW'(enq_s);
        end
        if (deq_s) begin
            discard_nxt_s = 1'b0;
        end else if (keep_s && rollback) begin
            discard_nxt_s = 1'b1;
        end else begin
            discard_nxt_s = discard_r;
        end
    end

    // Sign/zero extension of the load response according to the head func3.
    always_comb begin
        case (func3_r[head_r])
            FUNC3_LB:  ext_s = {{(XLEN-8){rsp_data_s[7]}}, rsp_data_s[7:0]};
            FUNC3_LH:  ext_s = {{(XLEN-16){rsp_data_s[15]}}, rsp_data_s[15:0]};
            FUNC3_LBU: ext_s = {{(XLEN-8){1'b0}}, rsp_data_s[7:0]};
            FUNC3_LHU: ext_s = {{(XLEN-16){1'b0}}, rsp_data_s[15:0]};
            default:   ext_s = rsp_data_s;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else if (rdy) begin
            state_r <= state_s;
        end
    end

    // Queue pointers, occupancy, committed count and discard flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r    <= '0;
            tail_r    <= '0;
            count_r   <= '0;
            ncommit_r <= '0;
            discard_r <= 1'b0;
        end else if (rdy) begin
            head_r    <= head_nxt_s;
            tail_r    <= tail_nxt_s;
            count_r   <= count_nxt_s;
            ncommit_r <= ncommit_nxt_s;
            discard_r <= discard_nxt_s;
        end
    end

    // Park a response that arrives while frozen until the queue runs again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_hold_r      <= 1'b0;
            rsp_hold_data_r <= '0;
        end else if (!rdy) begin
            if (mem.mem_rsp_valid) begin
                rsp_hold_r      <= 1'b1;
                rsp_hold_data_r <= mem.mem_rsp_data;
            end
        end else if (deq_s) begin
            rsp_hold_r <= 1'b0;
        end
    end

    // Entry storage: operand wakeup, commit marking, flush, dequeue and enqueue
    // (enqueue last so a same-slot dequeue+enqueue at full keeps the new entry).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r     <= '0;
            committed_r <= '0;
            is_store_r  <= '0;
            rs1_busy_r  <= '0;
            rs2_busy_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                func3_r[i]    <= 3'b000;
                rs1_data_r[i] <= '0;
                rs2_data_r[i] <= '0;
                rs1_tag_r[i]  <= '0;
                rs2_tag_r[i]  <= '0;
                imm_r[i]      <= '0;
                rob_r[i]      <= '0;
            end
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_r[i]) begin
                    if (rs1_busy_r[i] && w1_hit_s[i]) begin
                        rs1_busy_r[i] <= 1'b0;
                        rs1_data_r[i] <= w1_data_s[i];
                    end
                    if (rs2_busy_r[i] && w2_hit_s[i]) begin
                        rs2_busy_r[i] <= 1'b0;
                        rs2_data_r[i] <= w2_data_s[i];
                    end
                    if (commit_hit_s[i] && !rollback) begin
                        committed_r[i] <= 1'b1;
                    end
                    if (rollback && !committed_r[i] && !(keep_s && (head_r == AW'(i)))) begin
                        valid_r[i] <= 1'b0;
                    end
                end
            end
            if (deq_s) begin
                valid_r[head_r]     <= 1'b0;
                committed_r[head_r] <= 1'b0;
            end
            if (enq_s) begin
                valid_r[tail_r]     <= 1'b1;
                committed_r[tail_r] <= 1'b0;
                is_store_r[tail_r]  <= is_store;
                func3_r[tail_r]     <= func3;
                rs1_busy_r[tail_r]  <= rs1_busy && !e1_hit_s;
                rs2_busy_r[tail_r]  <= rs2_busy && !e2_hit_s;
                rs1_data_r[tail_r]  <= (rs1_busy && e1_hit_s) ? e1_data_s : rs1_data;
                rs2_data_r[tail_r]  <= (rs2_busy && e2_hit_s) ? e2_data_s : rs2_data;
                rs1_tag_r[tail_r]   <= rs1_rob_id;
                rs2_tag_r[tail_r]   <= rs2_rob_id;
                imm_r[tail_r]       <= imm;
                rob_r[tail_r]       <= rob_target;
            end
        end
    end

    // Registered memory request and load result broadcast.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_valid_r    <= 1'b0;
            mem_req_is_store_r <= 1'b0;
            mem_req_addr_r     <= '0;
            mem_req_len_r      <= 3'd0;
            mem_req_data_r     <= '0;
            out_valid          <= 1'b0;
            out_rob_id         <= '0;
            out_data           <= '0;
        end else if (rdy) begin
            out_valid <= 1'b0;
            if (issue_s) begin
                mem_req_valid_r    <= 1'b1;
                mem_req_is_store_r <= is_store_r[head_r];
                mem_req_addr_r     <= head_addr_s;
                mem_req_len_r      <= len_of(func3_r[head_r]);
                mem_req_data_r     <= rs2_data_r[head_r];
            end else if ((state_r == ST_REQ) && mem.mem_req_ready) begin
                mem_req_valid_r <= 1'b0;
            end
            if (deq_s && !is_store_r[head_r] && !discard_now_s) begin
                out_valid  <= 1'b1;
                out_rob_id <= rob_r[head_r];
                out_data   <= ext_s;
            end
        end
    end

endmodule
